jtag_tap_ctrl: RTL

Oversampled IEEE 1149.1 TAP controller running entirely in the in_sync_internal_clk domain. It sits directly downstream of the per-pin 3-flop input synchronizers on TCK/TMS/TDI. It detects TCK edges from the synchronized TCK level, runs the 16-state TAP FSM, and shifts the IR, BYPASS, IDCODE and one USER data register. It drives TDO and exposes the USER register to fabric logic with capture/update strobes.

---
 rtl/jtag_tap_ctrl_if.sv | 29 ++
 rtl/jtag_tap_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/jtag_tap_ctrl_if.sv
// jtag_tap_ctrl_if: pin-side and fabric-side signal bundle of the oversampled TAP controller
//   master modport (TAP pins + fabric driver):
//     out tck_sync, tms_sync, tdi_sync, user_capture_data
//     in  tdo, tdo_oe, tap_state, ir_out, user_dr_out, user_update, user_capture
//   slave modport (jtag_tap_ctrl): same signals, opposite directions
interface jtag_tap_ctrl_if #(
    parameter int IR_WIDTH      = 4,
    parameter int USER_DR_WIDTH = 8
);
    logic                     tck_sync;
    logic                     tms_sync;
    logic                     tdi_sync;
    logic [USER_DR_WIDTH-1:0] user_capture_data;
    logic                     tdo;
    logic                     tdo_oe;
    logic [3:0]               tap_state;
    logic [IR_WIDTH-1:0]      ir_out;
    logic [USER_DR_WIDTH-1:0] user_dr_out;
    logic                     user_update;
    logic                     user_capture;
    modport master (
        output tck_sync, tms_sync, tdi_sync, user_capture_data,
        input  tdo, tdo_oe, tap_state, ir_out, user_dr_out, user_update, user_capture
    );
    modport slave (
        input  tck_sync, tms_sync, tdi_sync, user_capture_data,
        output tdo, tdo_oe, tap_state, ir_out, user_dr_out, user_update, user_capture
    );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: oversampled IEEE 1149.1 TAP controller with IR, BYPASS, IDCODE and USER DRs
//   in_sync_internal_clk : system clock, all logic on posedge
//   in_sync_rstn         : asynchronous active-low reset
//   trst_sync            : synchronized active-low TRST (only when JTAG_TRST_EN is defined)
//   bus (slave)          : synchronized TCK/TMS/TDI, USER capture data in;
//                          TDO/TDO_OE, FSM state, active IR, USER parallel out and strobes out
// Optional feature macro: JTAG_TRST_EN adds the trst_sync input, which synchronously
// holds the FSM in Test-Logic-Reset and masks TCK edges while low.
module jtag_tap_ctrl #(
    parameter int                  IR_WIDTH      = 4,
    parameter logic [31:0]         IDCODE_VALUE  = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0] IDCODE_INSTR  = 4'b0001,
    parameter logic [IR_WIDTH-1:0] USER_INSTR    = 4'b0010,
    parameter int                  USER_DR_WIDTH = 8
) (
    input logic in_sync_internal_clk,
    input logic in_sync_rstn,
`ifdef JTAG_TRST_EN
    input logic trst_sync,
`endif
    jtag_tap_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        TLR = 4'hF, RTI = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
        PAUSE_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE,
        SH_IR = 4'hA, EX1_IR = 4'h9, PAUSE_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } state_t;

    state_t                   state_q, state_d;
    logic                     tck_q;
    logic [IR_WIDTH-1:0]      ir_sr_q, ir_sr_d, ir_q, ir_d;
    logic                     bypass_q, bypass_d;
    logic [31:0]              id_sr_q, id_sr_d;
    logic [USER_DR_WIDTH-1:0] user_sr_q, user_sr_d, user_dr_q, user_dr_d;
    logic                     tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;
    logic                     user_update_q, user_update_d, user_capture_q, user_capture_d;
    logic                     trst_n, tck_rise, tck_fall, sel_id, sel_user, tms, tdi;

`ifdef JTAG_TRST_EN
    assign trst_n = trst_sync;
`else
    assign trst_n = 1'b1;
`endif

    // TRST masks edge events so nothing shifts or updates while it is held
    assign tck_rise = bus.tck_sync & ~tck_q & trst_n;
    assign tck_fall = ~bus.tck_sync & tck_q & trst_n;
    assign tms      = bus.tms_sync;
    assign tdi      = bus.tdi_sync;
    assign sel_id   = ir_q == IDCODE_INSTR;
    assign sel_user = ir_q == USER_INSTR;

    always_ff @(posedge in_sync_internal_clk or negedge in_sync_rstn) begin
        if (!in_sync_rstn) begin
            state_q        <= TLR;
            tck_q          <= 1'b0;
            ir_sr_q        <= '0;
            ir_q           <= IDCODE_INSTR;
            bypass_q       <= 1'b0;
            id_sr_q        <= '0;
            user_sr_q      <= '0;
            user_dr_q      <= '0;
            tdo_q          <= 1'b0;
            tdo_oe_q       <= 1'b0;
            user_update_q  <= 1'b0;
            user_capture_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            tck_q          <= bus.tck_sync;
            ir_sr_q        <= ir_sr_d;
            ir_q           <= ir_d;
            bypass_q       <= bypass_d;
            id_sr_q        <= id_sr_d;
            user_sr_q      <= user_sr_d;
            user_dr_q      <= user_dr_d;
            tdo_q          <= tdo_d;
            tdo_oe_q       <= tdo_oe_d;
            user_update_q  <= user_update_d;
            user_capture_q <= user_capture_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ir_sr_d        = ir_sr_q;
        ir_d           = ir_q;
        bypass_d       = bypass_q;
        id_sr_d        = id_sr_q;
        user_sr_d      = user_sr_q;
        user_dr_d      = user_dr_q;
        tdo_d          = tdo_q;
        tdo_oe_d       = tdo_oe_q;
        user_update_d  = 1'b0;
        user_capture_d = 1'b0;
        if (tck_rise) begin
            case (state_q)
                TLR:      state_d = tms ? TLR      : RTI;
                RTI:      state_d = tms ? SEL_DR   : RTI;
                SEL_DR:   state_d = tms ? SEL_IR   : CAP_DR;
                CAP_DR:   state_d = tms ? EX1_DR   : SH_DR;
                SH_DR:    state_d = tms ? EX1_DR   : SH_DR;
                EX1_DR:   state_d = tms ? UPD_DR   : PAUSE_DR;
                PAUSE_DR: state_d = tms ? EX2_DR   : PAUSE_DR;
                EX2_DR:   state_d = tms ? UPD_DR   : SH_DR;
                UPD_DR:   state_d = tms ? SEL_DR   : RTI;
                SEL_IR:   state_d = tms ? TLR      : CAP_IR;
                CAP_IR:   state_d = tms ? EX1_IR   : SH_IR;
                SH_IR:    state_d = tms ? EX1_IR   : SH_IR;
                EX1_IR:   state_d = tms ? UPD_IR   : PAUSE_IR;
                PAUSE_IR: state_d = tms ? EX2_IR   : PAUSE_IR;
                EX2_IR:   state_d = tms ? UPD_IR   : SH_IR;
                UPD_IR:   state_d = tms ? SEL_DR   : RTI;
                default:  state_d = TLR;
            endcase
            if (state_q == CAP_IR) ir_sr_d = IR_WIDTH'(2'b01);
            if (state_q == SH_IR) ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};
            if (state_q == CAP_DR) begin
                bypass_d = 1'b0;
                if (sel_id) id_sr_d = IDCODE_VALUE;
                if (sel_user) begin
                    user_sr_d      = bus.user_capture_data;
                    user_capture_d = 1'b1;
                end
            end
            if (state_q == SH_DR) begin
                if (sel_id) id_sr_d = {tdi, id_sr_q[31:1]};
                // shift-and-or form keeps a 1-bit USER register legal
                else if (sel_user) user_sr_d = (user_sr_q >> 1) | (USER_DR_WIDTH'(tdi) << (USER_DR_WIDTH - 1));
                else bypass_d = tdi;
            end
        end
        if (tck_fall) begin
            tdo_oe_d = (state_q == SH_IR) || (state_q == SH_DR);
            if (state_q == SH_IR) tdo_d = ir_sr_q[0];
            if (state_q == SH_DR) tdo_d = sel_id ? id_sr_q[0] : sel_user ? user_sr_q[0] : bypass_q;
            if (state_q == UPD_IR) ir_d = ir_sr_q;
            if (state_q == UPD_DR && sel_user) begin
                user_dr_d     = user_sr_q;
                user_update_d = 1'b1;
            end
        end
        if (!trst_n) begin
            state_d  = TLR;
            tdo_oe_d = 1'b0;
        end
        // Test-Logic-Reset always restores the IDCODE instruction
        if (state_d == TLR) ir_d = IDCODE_INSTR;
    end

    assign bus.tdo          = tdo_q;
    assign bus.tdo_oe       = tdo_oe_q;
    assign bus.tap_state    = state_q;
    assign bus.ir_out       = ir_q;
    assign bus.user_dr_out  = user_dr_q;
    assign bus.user_update  = user_update_q;
    assign bus.user_capture = user_capture_q;
endmodule
